// File: rtl/srt_div_ctrl_if.sv
// Purpose: operand/result handshake bundle between the issue logic and the
//          radix-2 SRT divide controller.
// Signals:
//   in_valid/in_ready    operand pair handshake (dvd_i, dvs_i)
//   flush                synchronous abort of the in-flight operation
//   out_valid/out_ready  result handshake (quo_o, rem_o, dz_o)
//   busy_o               controller not idle
// Modports: master = issue side, slave = divide controller.
interface srt_div_ctrl_if #(parameter int WID = 8);
  logic           in_valid;
  logic           in_ready;
  logic [WID-1:0] dvd_i;
  logic [WID-1:0] dvs_i;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [WID-1:0] quo_o;
  logic [WID-1:0] rem_o;
  logic           dz_o;
  logic           busy_o;

  modport master (
    output in_valid, dvd_i, dvs_i, flush, out_ready,
    input  in_ready, out_valid, quo_o, rem_o, dz_o, busy_o
  );

  modport slave (
    input  in_valid, dvd_i, dvs_i, flush, out_ready,
    output in_ready, out_valid, quo_o, rem_o, dz_o, busy_o
  );
endinterface

// File: rtl/srt_div_ctrl.sv
// Purpose: iterative radix-2 SRT divider controller. One quotient digit per
//          clock from a redundant {-1,0,+1} digit set, on-the-fly quotient
//          conversion, final sign correction, fixed latency.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   srt_div_ctrl_if.slave: operand handshake, flush, result handshake,
//         busy indication
module srt_div_ctrl #(
  parameter int WID = 8
) (
  input  logic          clk,
  input  logic          rst,
  srt_div_ctrl_if.slave bus
);

  localparam int SW = $clog2(WID + 2);
  localparam int CW = $clog2(WID + 2);
  localparam int RW = WID + 2;

  typedef enum logic [2:0] {IDLE, NORM, ITER, FIX, DONE} state_t;

  state_t         state, state_nxt;
  logic [WID-1:0] dvd_q, dvs_q, dnorm;
  logic [SW-1:0]  shamt, lzc;
  logic [CW-1:0]  cnt;
  logic [RW-1:0]  w_q, w2, d2, w_next, w_fix;
  logic [WID-1:0] q_q, qm_q, q_fix;
  logic [WID-1:0] quo_q, rem_q, rem_next;
  logic           dz_q, dz_out_q;
  logic [2:0]     top3;
  logic           pos, neg, active, accept, in_ready;

  // Residual is kept against twice the normalised divisor, so the raw
  // dividend is already inside the convergence bound |W| <= 2D.
  assign w2   = {w_q[RW-2:0], 1'b0};
  assign d2   = {1'b0, dnorm, 1'b0};
  assign top3 = w_q[RW-1:RW-3];
  assign pos  = !top3[2] && (top3 != 3'b000);
  assign neg  = top3[2] && (top3 != 3'b111);

  always_comb begin
    w_next = w2;
    if (pos)      w_next = w2 - d2;
    else if (neg) w_next = w2 + d2;
  end

  // The first WID-s iteration slots leave the residual untouched, so only
  // s+1 digits are generated and Q lands as an integer quotient directly.
  assign active = (int'(cnt) + int'(shamt)) >= WID;

  always_comb begin
    lzc = SW'(WID);
    for (int i = 0; i < WID; i++)
      if (dvs_q[i]) lzc = SW'(WID - 1 - i);
  end

  assign w_fix    = w_q[RW-1] ? (w_q + d2) : w_q;
  assign q_fix    = w_q[RW-1] ? qm_q : q_q;
  assign rem_next = WID'(w_fix >> (shamt + SW'(1)));

  assign accept = bus.in_valid && in_ready && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) state_nxt = NORM;
        NORM: state_nxt = ITER;
        ITER: if (cnt == CW'(WID)) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: if (bus.out_ready) state_nxt = bus.in_valid ? NORM : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready      = (state == IDLE) || ((state == DONE) && bus.out_ready);
    bus.in_ready  = in_ready;
    bus.out_valid = (state == DONE);
    bus.busy_o    = (state != IDLE);
  end

  assign bus.quo_o = quo_q;
  assign bus.rem_o = rem_q;
  assign bus.dz_o  = dz_out_q;

  // QM tracks Q-1 so a -1 digit never needs a borrow through Q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q    <= '0;
      dvs_q    <= '0;
      dnorm    <= '0;
      shamt    <= '0;
      cnt      <= '0;
      w_q      <= '0;
      q_q      <= '0;
      qm_q     <= '0;
      dz_q     <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dz_out_q <= 1'b0;
    end else begin
      if (accept) begin
        dvd_q <= bus.dvd_i;
        dvs_q <= bus.dvs_i;
      end
      case (state)
        NORM: begin
          shamt <= lzc;
          dnorm <= dvs_q << lzc;
          w_q   <= {2'b00, dvd_q};
          q_q   <= '0;
          qm_q  <= '1;
          cnt   <= '0;
          dz_q  <= (dvs_q == '0);
        end
        ITER: begin
          cnt <= cnt + CW'(1);
          if (active) begin
            w_q <= w_next;
            if (pos) begin
              q_q  <= WID'({q_q, 1'b1});
              qm_q <= WID'({q_q, 1'b0});
            end else if (neg) begin
              q_q  <= WID'({qm_q, 1'b1});
              qm_q <= WID'({qm_q, 1'b0});
            end else begin
              q_q  <= WID'({q_q, 1'b0});
              qm_q <= WID'({qm_q, 1'b1});
            end
          end
        end
        FIX: begin
          if (!bus.flush) begin
            quo_q    <= dz_q ? '1 : q_fix;
            rem_q    <= dz_q ? dvd_q : rem_next;
            dz_out_q <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Purpose: self-checking bench for srt_div_ctrl. A cycle-level reference
//          (result = dvd / dvs, dvd % dvs, ready after a fixed latency) is
//          compared with the DUT on every falling edge; directed cases pin
//          literal results, latency, backpressure, back-to-back, flush, reset.
module tb_srt_div_ctrl;

  localparam int WID = 8;
  localparam int LAT = WID + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  srt_div_ctrl_if #(.WID(WID)) bus ();

  srt_div_ctrl #(.WID(WID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_done = 0;

  // Reference state: op in flight, cycles since its accept, expected result.
  logic           m_busy = 1'b0;
  int             m_age = 0;
  logic [WID-1:0] m_quo, m_rem;
  logic           m_dz;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic modelAccept(input logic [WID-1:0] a, input logic [WID-1:0] b);
    m_busy = 1'b1;
    m_age  = 1;
    if (b == '0) begin
      m_quo = '1;
      m_rem = a;
      m_dz  = 1'b1;
    end else begin
      m_quo = a / b;
      m_rem = a % b;
      m_dz  = 1'b0;
    end
  endtask

  // Compare every cycle, then advance the reference across the next edge.
  always @(negedge clk) begin
    logic exp_done;
    if (rst) begin
      m_busy = 1'b0;
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_in_ready", bus.in_ready, 1);
      checkOutput("rst_busy", bus.busy_o, 0);
      checkOutput("rst_quo", bus.quo_o, 0);
      checkOutput("rst_rem", bus.rem_o, 0);
      checkOutput("rst_dz", bus.dz_o, 0);
    end else begin
      exp_done = m_busy && (m_age >= LAT);
      checkOutput("out_valid", bus.out_valid, exp_done);
      checkOutput("busy", bus.busy_o, m_busy);
      checkOutput("in_ready", bus.in_ready, !m_busy || (exp_done && bus.out_ready));
      if (exp_done) begin
        checkOutput("quo", bus.quo_o, m_quo);
        checkOutput("rem", bus.rem_o, m_rem);
        checkOutput("dz", bus.dz_o, m_dz);
      end
      if (bus.flush) begin
        m_busy = 1'b0;
      end else if (exp_done) begin
        if (bus.out_ready) begin
          n_done++;
          m_busy = 1'b0;
          if (bus.in_valid) modelAccept(bus.dvd_i, bus.dvs_i);
        end
      end else if (m_busy) begin
        m_age++;
      end else if (bus.in_valid) begin
        modelAccept(bus.dvd_i, bus.dvs_i);
      end
    end
  end

  task automatic startOp(input logic [WID-1:0] a, input logic [WID-1:0] b);
    checkOutput("pre_in_ready", bus.in_ready, 1);
    bus.dvd_i    = a;
    bus.dvs_i    = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dvd_i    = ~a;
    bus.dvs_i    = a ^ b;
  endtask

  task automatic waitValid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic takeResult(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_single_hs"}, bus.out_valid, 0);
  endtask

  task automatic applyStimulus(input logic [WID-1:0] a, input logic [WID-1:0] b,
                               input logic [WID-1:0] eq, input logic [WID-1:0] er,
                               input logic edz, input int hold, input string tag);
    int lat;
    startOp(a, b);
    waitValid(lat);
    checkOutput({tag, "_latency"}, lat, LAT);
    for (int h = 0; h <= hold; h++) begin
      checkOutput({tag, "_quo"}, bus.quo_o, eq);
      checkOutput({tag, "_rem"}, bus.rem_o, er);
      checkOutput({tag, "_dz"}, bus.dz_o, edz);
      checkOutput({tag, "_held_valid"}, bus.out_valid, 1);
      checkOutput({tag, "_no_accept"}, bus.in_ready, 0);
      if (h < hold) begin
        @(posedge clk);
        #1;
      end
    end
    takeResult(tag);
  endtask

  initial begin
    int lat;
    int r;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.dvd_i     = '0;
    bus.dvs_i     = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 0, "d200_7");
    applyStimulus(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 0, "d255_1");
    applyStimulus(8'd128, 8'd128, 8'd1,   8'd0,  1'b0, 0, "d128_128");
    applyStimulus(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 0, "d5_9");
    applyStimulus(8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 0, "d0_5");
    applyStimulus(8'd13,  8'd0,   8'hFF,  8'd13, 1'b1, 0, "dz13");
    applyStimulus(8'd250, 8'd16,  8'd15,  8'd10, 1'b0, 5, "bp250_16");

    // Result accept and next operand accept in the same DONE cycle.
    startOp(8'd100, 8'd3);
    waitValid(lat);
    checkOutput("b2b_lat1", lat, LAT);
    checkOutput("b2b_quo1", bus.quo_o, 33);
    checkOutput("b2b_rem1", bus.rem_o, 1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dvd_i     = 8'd77;
    bus.dvs_i     = 8'd11;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checkOutput("b2b_no_gap_busy", bus.busy_o, 1);
    checkOutput("b2b_valid_drop", bus.out_valid, 0);
    waitValid(lat);
    checkOutput("b2b_lat2", lat, LAT);
    checkOutput("b2b_quo2", bus.quo_o, 7);
    checkOutput("b2b_rem2", bus.rem_o, 0);
    takeResult("b2b");

    // Flush during the fourth iteration cycle (cycle index 5 after accept).
    startOp(8'd200, 8'd7);
    repeat (4) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    checkOutput("flush_idle", bus.busy_o, 0);
    checkOutput("flush_in_ready", bus.in_ready, 1);
    for (int c = 0; c < 20; c++) begin
      checkOutput("flush_no_result", bus.out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Reset asserted during the correction cycle (cycle index 11).
    startOp(8'd99, 8'd4);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstfix_valid", bus.out_valid, 0);
    checkOutput("rstfix_busy", bus.busy_o, 0);
    checkOutput("rstfix_quo", bus.quo_o, 0);
    checkOutput("rstfix_rem", bus.rem_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checkOutput("rstfix_no_result", bus.out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Randomised traffic with backpressure and occasional flushes.
    for (int c = 0; c < 30000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 99) == 0);
      bus.dvd_i     = WID'($urandom);
      r = $urandom_range(0, 15);
      if (r == 0)     bus.dvs_i = '0;
      else if (r < 5) bus.dvs_i = WID'($urandom_range(1, 15));
      else            bus.dvs_i = WID'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    checkOutput("drain_idle", bus.busy_o, 0);
    checkOutput("random_progress", (n_done > 1000), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
